// File: rtl/mem2_port_arbiter.sv
// Data-side memory port arbiter: shares memory port 2 between the pipeline MEM stage (P)
// and the serial programmer (G), tracking read latency and generating the pipeline stall.
module mem2_port_arbiter #(
    parameter int READ_LAT  = 1,
    parameter int ADDR_W    = 32,
    parameter bit PROG_LOCK = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              PROG_ACTIVE,
    input  logic              P_REQ,
    input  logic              P_WE,
    input  logic [ADDR_W-1:0] P_ADDR,
    input  logic [31:0]       P_WDATA,
    input  logic [1:0]        P_SIZE,
    input  logic              P_SIGN,
    output logic              P_ACK,
    output logic [31:0]       P_RDATA,
    input  logic              G_REQ,
    input  logic              G_WE,
    input  logic [ADDR_W-1:0] G_ADDR,
    input  logic [31:0]       G_WDATA,
    output logic              G_ACK,
    output logic [31:0]       G_RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR2,
    output logic [31:0]       MEM_DIN2,
    output logic [1:0]        MEM_SIZE,
    output logic              MEM_SIGN,
    output logic              MEM_READ2,
    output logic              MEM_WRITE2,
    input  logic [31:0]       MEM_DOUT2,
    output logic              STALL_P
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, LOCKED} state_t;

    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);
    localparam logic [1:0] G_SIZE   = 2'b10;

    state_t      state_reg;
    logic        last_grant_g_reg;
    logic        rd_owner_g_reg;
    logic [1:0]  cnt_reg;
    logic        p_wack_reg;
    logic        g_wack_reg;
    logic [31:0] p_rdata_reg;
    logic [31:0] g_rdata_reg;

    logic lock_req;
    logic p_elig;
    logic g_elig;
    logic grant_p;
    logic grant_g;
    logic rd_issue;
    logic wr_issue;
    logic rd_done;

    assign lock_req = PROG_LOCK & PROG_ACTIVE;

    // In its write-ACK cycle P still presents the completing store (the stall releases only
    // there), so it must not be granted again in that cycle. Nothing is granted under reset.
    assign p_elig = RST_N & P_REQ & ~p_wack_reg;
    assign g_elig = RST_N & G_REQ;

    always_comb begin
        grant_p = 1'b0;
        grant_g = 1'b0;
        case (state_reg)
            IDLE: begin
                if (p_elig && g_elig) begin
                    if (lock_req || !last_grant_g_reg) begin
                        grant_g = 1'b1;
                    end else begin
                        grant_p = 1'b1;
                    end
                end else if (p_elig) begin
                    grant_p = 1'b1;
                end else if (g_elig) begin
                    grant_g = 1'b1;
                end
            end
            LOCKED: begin
                grant_g = g_elig & PROG_ACTIVE;
            end
            default: begin
                grant_p = 1'b0;
                grant_g = 1'b0;
            end
        endcase
    end

    assign rd_issue = (grant_p & ~P_WE) | (grant_g & ~G_WE);
    assign wr_issue = (grant_p &  P_WE) | (grant_g &  G_WE);
    assign rd_done  = (state_reg == RD_WAIT) && (cnt_reg == 2'd0);

    assign MEM_READ2  = rd_issue;
    assign MEM_WRITE2 = wr_issue;
    assign MEM_ADDR2  = grant_p ? P_ADDR  : (grant_g ? G_ADDR  : '0);
    assign MEM_DIN2   = grant_p ? P_WDATA : (grant_g ? G_WDATA : '0);
    assign MEM_SIZE   = grant_p ? P_SIZE  : (grant_g ? G_SIZE  : 2'b00);
    assign MEM_SIGN   = grant_p ? P_SIGN  : grant_g;

    // Read completion is visible in the cycle the memory data is valid; the hold register
    // keeps it afterwards.
    assign P_ACK   = p_wack_reg | (rd_done & ~rd_owner_g_reg);
    assign G_ACK   = g_wack_reg | (rd_done &  rd_owner_g_reg);
    assign P_RDATA = (rd_done && !rd_owner_g_reg) ? MEM_DOUT2 : p_rdata_reg;
    assign G_RDATA = (rd_done &&  rd_owner_g_reg) ? MEM_DOUT2 : g_rdata_reg;
    assign STALL_P = RST_N & P_REQ & ~P_ACK;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg        <= IDLE;
            last_grant_g_reg <= 1'b1;
            rd_owner_g_reg   <= 1'b0;
            cnt_reg          <= 2'd0;
            p_wack_reg       <= 1'b0;
            g_wack_reg       <= 1'b0;
            p_rdata_reg      <= 32'd0;
            g_rdata_reg      <= 32'd0;
        end else begin
            p_wack_reg <= grant_p & P_WE;
            g_wack_reg <= grant_g & G_WE;
            if (grant_p || grant_g) begin
                last_grant_g_reg <= grant_g;
            end
            case (state_reg)
                IDLE, LOCKED: begin
                    if (rd_issue) begin
                        state_reg      <= RD_WAIT;
                        cnt_reg        <= CNT_INIT;
                        rd_owner_g_reg <= grant_g;
                    end else if (state_reg == IDLE) begin
                        if (lock_req) begin
                            state_reg <= LOCKED;
                        end
                    end else if (!PROG_ACTIVE) begin
                        state_reg <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (cnt_reg == 2'd0) begin
                        if (rd_owner_g_reg) begin
                            g_rdata_reg <= MEM_DOUT2;
                        end else begin
                            p_rdata_reg <= MEM_DOUT2;
                        end
                        state_reg <= lock_req ? LOCKED : IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - 2'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem2_port_arbiter.sv
// Directed bench for mem2_port_arbiter: instance a uses READ_LAT=1, instance b uses READ_LAT=3,
// each with a small behavioural memory returning fixed data per address.
module tb_mem2_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst3_n = 1'b0;
    logic        prog_active = 1'b0;
    logic        p_req = 1'b0;
    logic        p_we = 1'b0;
    logic [31:0] p_addr = 32'd0;
    logic [31:0] p_wdata = 32'd0;
    logic [1:0]  p_size = 2'b00;
    logic        p_sign = 1'b0;
    logic        g_req = 1'b0;
    logic        g_we = 1'b0;
    logic [31:0] g_addr = 32'd0;
    logic [31:0] g_wdata = 32'd0;

    logic        p_ack_a, g_ack_a, mem_sign_a, mem_read2_a, mem_write2_a, stall_p_a;
    logic [31:0] p_rdata_a, g_rdata_a, mem_addr2_a, mem_din2_a;
    logic [31:0] mem_dout2_a = 32'd0;
    logic [1:0]  mem_size_a;

    logic        p_ack_b, g_ack_b, mem_sign_b, mem_read2_b, mem_write2_b, stall_p_b;
    logic [31:0] p_rdata_b, g_rdata_b, mem_addr2_b, mem_din2_b;
    logic [31:0] mem_dout2_b = 32'd0;
    logic [31:0] s1_b = 32'd0;
    logic [31:0] s2_b = 32'd0;
    logic [1:0]  mem_size_b;

    // control bundles: {READ2, WRITE2, STALL_P, P_ACK, G_ACK}
    logic [4:0] ctl_a, ctl_b;
    assign ctl_a = {mem_read2_a, mem_write2_a, stall_p_a, p_ack_a, g_ack_a};
    assign ctl_b = {mem_read2_b, mem_write2_b, stall_p_b, p_ack_b, g_ack_b};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem2_port_arbiter #(.READ_LAT(1)) dut_a (
        .CLK(clk), .RST_N(rst_n), .PROG_ACTIVE(prog_active),
        .P_REQ(p_req), .P_WE(p_we), .P_ADDR(p_addr), .P_WDATA(p_wdata),
        .P_SIZE(p_size), .P_SIGN(p_sign), .P_ACK(p_ack_a), .P_RDATA(p_rdata_a),
        .G_REQ(g_req), .G_WE(g_we), .G_ADDR(g_addr), .G_WDATA(g_wdata),
        .G_ACK(g_ack_a), .G_RDATA(g_rdata_a),
        .MEM_ADDR2(mem_addr2_a), .MEM_DIN2(mem_din2_a), .MEM_SIZE(mem_size_a),
        .MEM_SIGN(mem_sign_a), .MEM_READ2(mem_read2_a), .MEM_WRITE2(mem_write2_a),
        .MEM_DOUT2(mem_dout2_a), .STALL_P(stall_p_a)
    );

    mem2_port_arbiter #(.READ_LAT(3)) dut_b (
        .CLK(clk), .RST_N(rst3_n), .PROG_ACTIVE(prog_active),
        .P_REQ(p_req), .P_WE(p_we), .P_ADDR(p_addr), .P_WDATA(p_wdata),
        .P_SIZE(p_size), .P_SIGN(p_sign), .P_ACK(p_ack_b), .P_RDATA(p_rdata_b),
        .G_REQ(g_req), .G_WE(g_we), .G_ADDR(g_addr), .G_WDATA(g_wdata),
        .G_ACK(g_ack_b), .G_RDATA(g_rdata_b),
        .MEM_ADDR2(mem_addr2_b), .MEM_DIN2(mem_din2_b), .MEM_SIZE(mem_size_b),
        .MEM_SIGN(mem_sign_b), .MEM_READ2(mem_read2_b), .MEM_WRITE2(mem_write2_b),
        .MEM_DOUT2(mem_dout2_b), .STALL_P(stall_p_b)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        case (a)
            32'h0000_0200: mem_val = 32'h1234_5678;
            32'h0000_0000: mem_val = 32'hCAFE_F00D;
            default:       mem_val = {a[15:0], 16'h5A5A};
        endcase
    endfunction

    // Memories drive junk when no read was issued so stale-data bugs are visible.
    always @(posedge clk) begin
        mem_dout2_a <= mem_read2_a ? mem_val(mem_addr2_a) : 32'h0BAD_0BAD;
        s1_b        <= mem_read2_b ? mem_val(mem_addr2_b) : 32'h0BAD_0BAD;
        s2_b        <= s1_b;
        mem_dout2_b <= s2_b;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst ctl", 32'(ctl_a), 32'h0);
        check_eq("rst p_rdata", p_rdata_a, 32'h0);
        check_eq("rst g_rdata", g_rdata_a, 32'h0);
        check_eq("rst mem_addr", mem_addr2_a, 32'h0);
        check_eq("rst mem_din", mem_din2_a, 32'h0);
        check_eq("rst size/sign", 32'({mem_size_a, mem_sign_a}), 32'h0);
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h100; p_wdata = 32'hDEAD_BEEF; p_size = 2'b10;
        #1;
        check_eq("rst gated ctl", 32'(ctl_a), 32'h0);
        check_eq("rst gated addr", mem_addr2_a, 32'h0);
        p_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- P word write ----------------
        next_cycle; p_req = 1'b1; #1;
        check_eq("wr grant ctl", 32'(ctl_a), 32'b01100);
        check_eq("wr grant addr", mem_addr2_a, 32'h100);
        check_eq("wr grant din", mem_din2_a, 32'hDEAD_BEEF);
        check_eq("wr grant size/sign", 32'({mem_size_a, mem_sign_a}), 32'b100);
        next_cycle; #1;
        check_eq("wr ack ctl", 32'(ctl_a), 32'b00010);
        next_cycle; p_req = 1'b0; #1;
        check_eq("wr after ctl", 32'(ctl_a), 32'b00000);

        // ---------------- P word read, latency 1 ----------------
        next_cycle; p_req = 1'b1; p_we = 1'b0; p_addr = 32'h200; #1;
        check_eq("rd grant ctl", 32'(ctl_a), 32'b10100);
        check_eq("rd grant addr", mem_addr2_a, 32'h200);
        next_cycle; #1;
        check_eq("rd ack ctl", 32'(ctl_a), 32'b00010);
        check_eq("rd ack data", p_rdata_a, 32'h1234_5678);
        next_cycle; p_req = 1'b0; #1;
        check_eq("rd idle ctl", 32'(ctl_a), 32'b00000);
        check_eq("rd data held", p_rdata_a, 32'h1234_5678);

        // ---------------- G write alone ----------------
        next_cycle; g_req = 1'b1; g_we = 1'b1; g_addr = 32'h300; g_wdata = 32'h1111_2222; #1;
        check_eq("g wr ctl", 32'(ctl_a), 32'b01000);
        check_eq("g wr addr", mem_addr2_a, 32'h300);
        check_eq("g wr size/sign", 32'({mem_size_a, mem_sign_a}), 32'b101);
        next_cycle; g_req = 1'b0; #1;
        check_eq("g wr ack ctl", 32'(ctl_a), 32'b00001);

        // ---------------- tie 1: last grant G, P first ----------------
        next_cycle;
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h400; p_wdata = 32'h44;
        g_req = 1'b1; g_we = 1'b1; g_addr = 32'h500; g_wdata = 32'h55;
        #1;
        check_eq("tie1 first ctl", 32'(ctl_a), 32'b01100);
        check_eq("tie1 first addr", mem_addr2_a, 32'h400);
        next_cycle; #1;
        check_eq("tie1 second ctl", 32'(ctl_a), 32'b01010);
        check_eq("tie1 second addr", mem_addr2_a, 32'h500);
        check_eq("tie1 second din", mem_din2_a, 32'h55);
        next_cycle; p_req = 1'b0; g_req = 1'b0; #1;
        check_eq("tie1 g ack ctl", 32'(ctl_a), 32'b00001);

        // P write alone so that P was granted last
        next_cycle; p_req = 1'b1; p_addr = 32'h480; p_wdata = 32'h48; #1;
        check_eq("p alone ctl", 32'(ctl_a), 32'b01100);
        next_cycle; #1;
        next_cycle; p_req = 1'b0;

        // ---------------- tie 2: last grant P, G first ----------------
        next_cycle;
        p_req = 1'b1; p_addr = 32'h600; p_wdata = 32'h66;
        g_req = 1'b1; g_addr = 32'h700; g_wdata = 32'h77;
        #1;
        check_eq("tie2 first ctl", 32'(ctl_a), 32'b01100);
        check_eq("tie2 first addr", mem_addr2_a, 32'h700);
        next_cycle; g_req = 1'b0; #1;
        check_eq("tie2 second ctl", 32'(ctl_a), 32'b01101);
        check_eq("tie2 second addr", mem_addr2_a, 32'h600);
        next_cycle; #1;
        check_eq("tie2 p ack ctl", 32'(ctl_a), 32'b00010);
        next_cycle; p_req = 1'b0;

        // ---------------- programmer lock ----------------
        next_cycle; prog_active = 1'b1; #1;
        check_eq("lock enter ctl", 32'(ctl_a), 32'b00000);
        next_cycle;
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h800; p_wdata = 32'h88;
        g_req = 1'b1; g_we = 1'b1; g_addr = 32'h1000; g_wdata = 32'hA000_0000;
        #1;
        check_eq("lock g0 ctl", 32'(ctl_a), 32'b01100);
        check_eq("lock g0 addr", mem_addr2_a, 32'h1000);
        for (int i = 1; i < 4; i++) begin
            next_cycle;
            g_addr = 32'h1000 + 32'(4 * i);
            g_wdata = 32'hA000_0000 + 32'(i);
            #1;
            check_eq($sformatf("lock g%0d ctl", i), 32'(ctl_a), 32'b01101);
            check_eq($sformatf("lock g%0d din", i), mem_din2_a, 32'hA000_0000 + 32'(i));
        end
        next_cycle; g_req = 1'b0; prog_active = 1'b0; #1;
        check_eq("lock g3 ack ctl", 32'(ctl_a), 32'b00101);
        next_cycle; #1;
        check_eq("unlock p ctl", 32'(ctl_a), 32'b01100);
        check_eq("unlock p addr", mem_addr2_a, 32'h800);
        next_cycle; #1;
        check_eq("unlock p ack ctl", 32'(ctl_a), 32'b00010);
        next_cycle; p_req = 1'b0; rst3_n = 1'b1; #1;
        check_eq("lat3 out of reset ctl", 32'(ctl_b), 32'b00000);

        // ---------------- READ_LAT=3 G read, P waits ----------------
        next_cycle; g_req = 1'b1; g_we = 1'b0; g_addr = 32'h0; #1;
        check_eq("lat3 rd grant ctl", 32'(ctl_b), 32'b10000);
        check_eq("lat3 rd size/sign", 32'({mem_size_b, mem_sign_b}), 32'b101);
        next_cycle; p_req = 1'b1; p_we = 1'b1; p_addr = 32'h900; p_wdata = 32'h99; #1;
        check_eq("lat3 wait1 ctl", 32'(ctl_b), 32'b00100);
        next_cycle; #1;
        check_eq("lat3 wait2 ctl", 32'(ctl_b), 32'b00100);
        next_cycle; #1;
        check_eq("lat3 ack ctl", 32'(ctl_b), 32'b00101);
        check_eq("lat3 ack data", g_rdata_b, 32'hCAFE_F00D);
        next_cycle; g_req = 1'b0; #1;
        check_eq("lat3 p grant ctl", 32'(ctl_b), 32'b01100);
        check_eq("lat3 p grant addr", mem_addr2_b, 32'h900);
        check_eq("lat3 g data held", g_rdata_b, 32'hCAFE_F00D);
        next_cycle; #1;
        check_eq("lat3 p ack ctl", 32'(ctl_b), 32'b00010);
        next_cycle; p_req = 1'b0;

        // ---------------- reset during a read ----------------
        next_cycle; g_req = 1'b1; g_we = 1'b0; g_addr = 32'h4; #1;
        check_eq("rstrd grant ctl", 32'(ctl_b), 32'b10000);
        next_cycle;
        rst3_n = 1'b0; g_req = 1'b0;
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'hA00; p_wdata = 32'hAA;
        #1;
        check_eq("rstrd ctl", 32'(ctl_b), 32'b00000);
        check_eq("rstrd g data", g_rdata_b, 32'h0);
        check_eq("rstrd addr", mem_addr2_b, 32'h0);
        next_cycle; #1;
        check_eq("rstrd hold1 ctl", 32'(ctl_b), 32'b00000);
        next_cycle; #1;
        check_eq("rstrd hold2 ctl", 32'(ctl_b), 32'b00000);
        next_cycle; rst3_n = 1'b1; #1;
        check_eq("rstrd p grant ctl", 32'(ctl_b), 32'b01100);
        check_eq("rstrd p grant addr", mem_addr2_b, 32'hA00);
        check_eq("rstrd p grant din", mem_din2_b, 32'hAA);
        next_cycle; #1;
        check_eq("rstrd p ack ctl", 32'(ctl_b), 32'b00010);
        next_cycle; p_req = 1'b0; #1;
        check_eq("rstrd idle ctl", 32'(ctl_b), 32'b00000);
        check_eq("rstrd g data after", g_rdata_b, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
